// File: rtl/four_bit_full_adder_pkg.sv
// Shared width and operand type for the registered ripple-carry adder.
package four_bit_full_adder_pkg;

   localparam int ADDER_WIDTH = 4;

   typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage : four_bit_full_adder_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell; purely combinational link in the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   // Propagate term is shared by the sum and the carry-out.
   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/four_bit_full_adder.sv
// Registered ripple-carry adder: {Cout, S} = A + B + Cin, one cycle after sampling.
module four_bit_full_adder
   import four_bit_full_adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s_d;
   logic [WIDTH-1:0] s_q;
   logic             cout_q;

   assign c[0] = Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (c[i]),
         .s    (s_d[i]),
         .cout (c[i+1])
      );
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= c[WIDTH];
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;

endmodule : four_bit_full_adder

// File: tb/tb_four_bit_full_adder.sv
// Self-checking bench: directed table, exhaustive sweep, latency, reset and truncation cases.
module tb_four_bit_full_adder;
   import four_bit_full_adder_pkg::*;

   logic     clk;
   logic     rst_n;
   operand_t a;
   operand_t b;
   logic     cin;
   operand_t s;
   logic     cout;

   int checks;
   int errors;

   typedef struct {
      operand_t a;
      operand_t b;
      logic     cin;
      operand_t exp_s;
      logic     exp_cout;
   } vec_t;

   vec_t vecs[8];

   four_bit_full_adder #(.WIDTH(ADDER_WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a),
      .B     (b),
      .Cin   (cin),
      .S     (s),
      .Cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {Cout,S}=%0d (0x%02h) expected %0d (0x%02h)", name, got, got, exp, exp);
      end
   endtask

   task automatic drive(input operand_t va, input operand_t vb, input logic vc);
      a   = va;
      b   = vb;
      cin = vc;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] a_wide;
      logic [1:0] cin_wide;

      checks = 0;
      errors = 0;

      vecs[0] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
      vecs[1] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
      vecs[2] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
      vecs[3] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
      vecs[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
      vecs[5] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
      vecs[6] = '{4'h1, 4'h2, 1'b1, 4'h4, 1'b0};
      vecs[7] = '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0};

      // Reset held with all-ones inputs and the clock running.
      rst_n = 1'b0;
      drive(4'hF, 4'hF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_hold", {cout, s}, 5'd0);
      end
      rst_n = 1'b1;
      step();
      check("reset_release", {cout, s}, {1'b1, 4'hF});

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(vecs[i].a, vecs[i].b, vecs[i].cin);
         step();
         check($sformatf("table[%0d]", i), {cout, s}, {vecs[i].exp_cout, vecs[i].exp_s});
      end

      // Exhaustive sweep, one vector per cycle.
      for (int ci = 0; ci < 2; ci++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               drive(operand_t'(ai), operand_t'(bi), 1'(ci));
               step();
               check($sformatf("sweep a=%0d b=%0d cin=%0d", ai, bi, ci), {cout, s}, 5'(ai + bi + ci));
            end
         end
      end

      // Latency: one cycle, stable between edges.
      @(negedge clk);
      drive(4'd3, 4'd4, 1'b0);
      step();
      check("latency_edge_n", {cout, s}, 5'd7);
      drive(4'd1, 4'd1, 1'b0);
      @(negedge clk);
      check("latency_between", {cout, s}, 5'd7);
      step();
      check("latency_edge_n1", {cout, s}, 5'd2);

      // Asynchronous reset mid-cycle with 9 latched.
      drive(4'd4, 4'd5, 1'b0);
      step();
      check("pre_async_reset", {cout, s}, 5'd9);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", {cout, s}, 5'd0);
      step();
      check("async_reset_held", {cout, s}, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Truncation of wider drivers to port width.
      a_wide   = 5'h1F;
      cin_wide = 2'b10;
      drive(a_wide[3:0], 4'h0, cin_wide[0]);
      step();
      check("truncation", {cout, s}, {1'b0, 4'hF});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_four_bit_full_adder
